// File: rtl/frame_update_arbiter.sv
// Frame-synchronous update arbiter between game logic and the VGA renderer.
// On entry to vertical blanking it snapshots the game state word and grants the
// renderer's single bullet slot to one of four requesters, round-robin, so that
// renderer inputs only ever change during blanking.
//
// Ports:
//   clk, reset          system clock, asynchronous active-high reset
//   p_tick, x, y        pixel strobe and raster position from vga_sync
//   state_in            live game state word
//   src_valid/pos/color per-source bullet requests (4 sources, packed)
//   src_ack             one-hot, one-cycle grant acknowledge (driven in COMMIT)
//   state_out           frame-stable state word
//   bullet_pos/color    frame-stable bullet attributes of the last grant
//   is_render           bullet present this frame
//   grant_idx           index of the last granted source
//   frame_start         one-cycle pulse the clk after the first pixel of a frame
//   frame_cnt           frames since reset, wrapping
module frame_update_arbiter #(
    parameter int unsigned N_SRC    = 4,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned H_MAX    = 799
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        p_tick,
    input  logic [9:0]  x,
    input  logic [9:0]  y,
    input  logic [31:0] state_in,
    input  logic [3:0]  src_valid,
    input  logic [63:0] src_pos,
    input  logic [7:0]  src_color,
    output logic [3:0]  src_ack,
    output logic [31:0] state_out,
    output logic [15:0] bullet_pos,
    output logic [1:0]  bullet_color,
    output logic        is_render,
    output logic [1:0]  grant_idx,
    output logic        frame_start,
    output logic [7:0]  frame_cnt
);

    typedef enum logic [1:0] {
        ST_ACTIVE = 2'd0,
        ST_GRANT  = 2'd1,
        ST_COMMIT = 2'd2,
        ST_BLANK  = 2'd3
    } state_t;

    state_t     state_q;
    state_t     state_d;
    logic [1:0] rr_ptr;
    logic [1:0] win_idx;
    logic       win_any;
    logic [1:0] srch_idx;
    logic [1:0] cand;
    logic       srch_any;
    logic       capture_en;
    logic       commit_en;
    logic       x_ok;
    logic       vb_trig;
    logic       fs_trig;

    // Raster events; x beyond the line length never qualifies as a trigger.
    assign x_ok    = (x <= 10'(H_MAX));
    assign vb_trig = p_tick && x_ok && (x == 10'd0) && (y == 10'(V_ACTIVE));
    assign fs_trig = p_tick && x_ok && (x == 10'd0) && (y == 10'd0);

    // Round-robin search from rr_ptr upward; descending loop lets the nearest hit win.
    always_comb begin
        srch_any = 1'b0;
        srch_idx = rr_ptr;
        cand     = rr_ptr;
        for (int k = int'(N_SRC) - 1; k >= 0; k--) begin
            cand = rr_ptr + 2'(k);
            if (src_valid[cand]) begin
                srch_any = 1'b1;
                srch_idx = cand;
            end
        end
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_ACTIVE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; vb_trig outside ACTIVE is ignored so a frame commits once.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_ACTIVE: if (vb_trig) state_d = ST_GRANT;
            ST_GRANT:  state_d = ST_COMMIT;
            ST_COMMIT: state_d = ST_BLANK;
            ST_BLANK:  if (fs_trig) state_d = ST_ACTIVE;
            default:   state_d = ST_ACTIVE;
        endcase
    end

    // Output decode: datapath enables and the COMMIT-only acknowledge.
    always_comb begin
        src_ack    = 4'b0000;
        capture_en = 1'b0;
        commit_en  = 1'b0;
        case (state_q)
            ST_GRANT:  capture_en = 1'b1;
            ST_COMMIT: begin
                commit_en = 1'b1;
                if (win_any) src_ack[win_idx] = 1'b1;
            end
            default: ;
        endcase
    end

    // Frame-stable renderer registers, arbitration state and frame pacing.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_out    <= 32'd0;
            bullet_pos   <= 16'd0;
            bullet_color <= 2'd0;
            is_render    <= 1'b0;
            grant_idx    <= 2'd0;
            rr_ptr       <= 2'd0;
            win_idx      <= 2'd0;
            win_any      <= 1'b0;
            frame_start  <= 1'b0;
            frame_cnt    <= 8'd0;
        end else begin
            frame_start <= fs_trig;
            if (fs_trig) frame_cnt <= frame_cnt + 8'd1;

            if (capture_en) begin
                state_out <= state_in;
                win_idx   <= srch_idx;
                win_any   <= srch_any;
            end

            // Position/colour are taken now, one cycle after valid was sampled.
            if (commit_en) begin
                if (win_any) begin
                    bullet_pos   <= src_pos[{win_idx, 4'b0000} +: 16];
                    bullet_color <= src_color[{win_idx, 1'b0} +: 2];
                    is_render    <= 1'b1;
                    grant_idx    <= win_idx;
                    rr_ptr       <= win_idx + 2'd1;
                end else begin
                    is_render <= 1'b0;
                end
            end
        end
    end

endmodule

// File: doc/frame_update_arbiter.md
Name: frame_update_arbiter

Overview:
- Frame-synchronous controller between game logic and the VGA renderer.
- Once per frame, on entry to vertical blanking, it snapshots the game state word.
- At the same point it grants the renderer's single bullet slot (position, colour, render enable) to one of N_SRC bullet requesters, chosen round-robin.
- Renderer inputs therefore change only during blanking, which removes mid-frame tearing. A frame_start pulse and a frame counter let game logic pace its updates.

Parameters:
- N_SRC, 4, number of bullet requesters. Fixed at 4; grant index is 2 bits.
- V_ACTIVE, 480, first non-visible line; vblank trigger line.
- H_MAX, 799, last horizontal count. Used only for range checking; not for sequencing.

Ports:
- clk  in  1  system clock (100 MHz)
- reset  in  1  asynchronous, active-high reset
- p_tick  in  1  pixel-enable strobe from vga_sync, 1 clk in 4
- x  in  10  current horizontal pixel count
- y  in  10  current vertical line count
- state_in  in  32  live game state word
- src_valid  in  4  per-source bullet request; held until acked
- src_pos  in  64  source i position at [16i+15:16i], {x[7:0], y[7:0]}
- src_color  in  8  source i colour at [2i+1:2i]
- src_ack  out  4  one-cycle grant acknowledge, one-hot
- state_out  out  32  frame-stable state word to renderer
- bullet_pos  out  16  frame-stable bullet position
- bullet_color  out  2  frame-stable bullet colour
- is_render  out  1  bullet present this frame
- grant_idx  out  2  index of last granted source
- frame_start  out  1  one-cycle pulse at first pixel of a frame
- frame_cnt  out  8  frames since reset, wraps 255→0

Behaviour:

Reset (asynchronous, active-high):
- All outputs go to 0.
- rr_ptr=0, FSM=ACTIVE.
- Reset mid-BLANK: no commit for that frame. The first commit is at the next vblank trigger.

Event definitions:
- vb_trig = p_tick && x==0 && y==V_ACTIVE
- fs_trig = p_tick && x==0 && y==0

FSM states:
- ACTIVE: outputs frozen. On vb_trig go to GRANT.
- GRANT (exactly 1 clk):
  - state_out <= state_in.
  - Search src_valid starting at rr_ptr, ascending mod 4; the first set bit is the winner.
  - Register win_idx and win_any.
  - Go to COMMIT.
- COMMIT (exactly 1 clk):
  - If win_any:
    - bullet_pos <= src_pos[win_idx]
    - bullet_color <= src_color[win_idx]
    - is_render <= 1
    - grant_idx <= win_idx
    - src_ack[win_idx] = 1 for this cycle only
    - rr_ptr <= win_idx+1 mod 4
  - Else:
    - is_render <= 0
    - bullet_pos, bullet_color, grant_idx and rr_ptr keep their values
  - Go to BLANK.
- BLANK: on fs_trig go to ACTIVE.

frame_start and frame_cnt:
- frame_start is asserted combinationally-registered: it is 1 for the clk following fs_trig.
- This happens in any state, including ACTIVE, so the first frame after reset still pulses.
- frame_cnt increments in the same cycle that frame_start is high.

Timing and ordering rules:
- Latency from vb_trig to updated outputs: 2 clk. state_out updates 1 clk after vb_trig; bullet outputs update 2 clk after vb_trig.
- src_valid is sampled in GRANT only.
- src_pos and src_color are sampled in COMMIT. Sources must hold valid, pos and colour stable until ack.
- A source that deasserts valid before COMMIT still gets the grant if it was sampled in GRANT.
- src_ack is never asserted outside COMMIT. At most one bit is set.

Boundary conditions:
- vb_trig while in GRANT, COMMIT or BLANK: ignored. This cannot occur with legal timing but must not double-commit.
- state_in changes during ACTIVE: no effect on state_out.
- All four sources valid, persistent: grant order is 0,1,2,3,0,… on successive frames.
- x/y values outside the display range other than the trigger lines: no effect.

Test Plan:
- Reset released, no requests, state_in=0x9000_6464, run 1 frame:
  - state_out=0x9000_6464 at vb_trig+1 clk.
  - is_render=0, src_ack never set, frame_start seen once, frame_cnt=1.
- src_valid=4'b1111 held for 5 frames, src_pos[i]=16'h1010*(i+1):
  - Grants go 0,1,2,3,0.
  - bullet_pos per frame is 1010, 2020, 3030, 4040, 1010.
  - Each src_ack is a single clk pulse in COMMIT.
- src_valid=4'b1000, rr_ptr=0:
  - Winner is 3, bullet_color=src_color[3], rr_ptr becomes 0.
  - Next frame with only src_valid[1] set: winner is 1.
- Change state_in and src_pos at y=200 mid-frame:
  - state_out, bullet_pos and is_render stay unchanged until y=480, x=0.
- Assert reset for 3 clk at y=500 with is_render=1:
  - All outputs go 0 immediately.
  - No commit occurs until the next y=480 trigger.
- Run 256 frames:
  - frame_cnt wraps 255→0 on the 256th frame_start.
